// File: rtl/ame_pkg.sv
// Shared types and index helpers for the affine-ME normal-equation builder.
// The 6x6 symmetric A matrix is stored as its 21-entry upper triangle.
package ame_pkg;

    localparam int AME_NUM_PARAM = 32'sd6;
    localparam int AME_NUM_COL   = 32'sd7;
    localparam int AME_NUM_TRI   = 32'sd21;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        DRAIN1    = 3'd2,
        DRAIN2    = 3'd3,
        WAIT_LOAD = 3'd4
    } ame_state_e;

    // Row-major upper-triangle slot for element (row, col); symmetric in its arguments.
    function automatic int tri_idx(input int row, input int col);
        int lo;
        int hi;
        lo = (row <= col) ? row : col;
        hi = (row <= col) ? col : row;
        return lo * AME_NUM_PARAM - ((lo * (lo - 32'sd1)) / 32'sd2) + (hi - lo);
    endfunction

endpackage

// File: rtl/ame_outer_product.sv
// Stage 1: registers the 21 upper-triangle products c_i*c_j and the 6 products c_i*r.
// In 4-parameter mode c0 and c1 are zeroed before multiplication.
module ame_outer_product
    import ame_pkg::*;
#(
    parameter int SAMP_BITS = 24
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic                                       i_valid,
    input  logic                                       i_first,
    input  logic                                       i_mode,
    input  logic [AME_NUM_PARAM-1:0][SAMP_BITS-1:0]    i_coef,
    input  logic [SAMP_BITS-1:0]                       i_resid,
    output logic                                       o_valid,
    output logic                                       o_first,
    output logic                                       o_mode,
    output logic [AME_NUM_TRI-1:0][2*SAMP_BITS-1:0]    o_prod_a,
    output logic [AME_NUM_PARAM-1:0][2*SAMP_BITS-1:0]  o_prod_b
);

    logic [AME_NUM_PARAM-1:0][2*SAMP_BITS-1:0] w_coef_x;
    logic [2*SAMP_BITS-1:0]                    w_resid_x;
    logic                                      r_valid;
    logic                                      r_first;
    logic                                      r_mode;
    logic [AME_NUM_TRI-1:0][2*SAMP_BITS-1:0]   r_prod_a;
    logic [AME_NUM_PARAM-1:0][2*SAMP_BITS-1:0] r_prod_b;

    // Sign-extend operands to product width so the truncated product is exact.
    always_comb begin
        w_coef_x = '0;
        for (int k = 0; k < AME_NUM_PARAM; k++) begin
            if (!i_mode && (k < 32'sd2)) begin
                w_coef_x[k] = '0;
            end else begin
                w_coef_x[k] = {{SAMP_BITS{i_coef[k][SAMP_BITS-1]}}, i_coef[k]};
            end
        end
        w_resid_x = {{SAMP_BITS{i_resid[SAMP_BITS-1]}}, i_resid};
    end

    // Product registers plus valid/first/mode tags travelling with them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_mode   <= 1'b0;
            r_prod_a <= '0;
            r_prod_b <= '0;
        end else begin
            r_valid <= i_valid;
            r_first <= i_valid & i_first;
            r_mode  <= i_mode;
            if (i_valid) begin
                for (int i = 0; i < AME_NUM_PARAM; i++) begin
                    for (int j = i; j < AME_NUM_PARAM; j++) begin
                        r_prod_a[tri_idx(i, j)] <= w_coef_x[i] * w_coef_x[j];
                    end
                    r_prod_b[i] <= w_coef_x[i] * w_resid_x;
                end
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_first  = r_first;
    assign o_mode   = r_mode;
    assign o_prod_a = r_prod_a;
    assign o_prod_b = r_prod_b;

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates per-sample gradients/residuals into the 6x7 augmented normal-equation
// system and hands it to the solver via the comp_load/comp_init handshake.
module ame_equation_builder
    import ame_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64,
    parameter int SAMP_BITS      = 24
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_n_i,
    input  logic                                                    samp_valid_i,
    output logic                                                    samp_ready_o,
    input  logic                                                    samp_last_i,
    input  logic [AME_NUM_PARAM-1:0][SAMP_BITS-1:0]                 samp_coef_i,
    input  logic [SAMP_BITS-1:0]                                    samp_resid_i,
    input  logic                                                    affine_param6_i,
    input  logic                                                    comp_load_i,
    output logic                                                    comp_init_o,
    output logic [AME_NUM_PARAM-1:0][AME_NUM_COL-1:0][COMP_DATA_BITS-1:0] comp_data_o,
    output logic [7:0]                                              comp_data_index_o,
    output logic                                                    affine_param6_o
);

    localparam int PROD_BITS = 2 * SAMP_BITS;
    localparam int EXT_BITS  = COMP_DATA_BITS - PROD_BITS;

    ame_state_e r_state;
    ame_state_e w_state_nxt;
    logic       r_samp_ready;
    logic       w_samp_ready_nxt;
    logic       r_comp_init;
    logic       w_comp_init_nxt;
    logic [7:0] r_index;
    logic       r_mode_cur;
    logic       r_affine6;
    logic       w_accept;
    logic       w_first;
    logic       w_mode;

    logic                                       w_p_valid;
    logic                                       w_p_first;
    logic                                       w_p_mode;
    logic [AME_NUM_TRI-1:0][PROD_BITS-1:0]      w_prod_a;
    logic [AME_NUM_PARAM-1:0][PROD_BITS-1:0]    w_prod_b;
    logic [AME_NUM_TRI-1:0][COMP_DATA_BITS-1:0] r_acc_a;
    logic [AME_NUM_PARAM-1:0][COMP_DATA_BITS-1:0] r_acc_b;

    function automatic logic [COMP_DATA_BITS-1:0] sext(input logic [PROD_BITS-1:0] p);
        return {{EXT_BITS{p[PROD_BITS-1]}}, p};
    endfunction

    assign w_accept = samp_valid_i & r_samp_ready;
    assign w_first  = w_accept & (r_state == IDLE);
    // Later samples reuse the mode captured with the first sample of the system.
    assign w_mode   = (r_state == IDLE) ? affine_param6_i : r_mode_cur;

    ame_outer_product #(
        .SAMP_BITS (SAMP_BITS)
    ) u_outer_product (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_valid  (w_accept),
        .i_first  (w_first),
        .i_mode   (w_mode),
        .i_coef   (samp_coef_i),
        .i_resid  (samp_resid_i),
        .o_valid  (w_p_valid),
        .o_first  (w_p_first),
        .o_mode   (w_p_mode),
        .o_prod_a (w_prod_a),
        .o_prod_b (w_prod_b)
    );

    // Next-state and start-pulse decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_comp_init_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = samp_last_i ? DRAIN1 : ACCUM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (w_accept && samp_last_i) begin
                    w_state_nxt = DRAIN1;
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            DRAIN1:  w_state_nxt = DRAIN2;
            DRAIN2:  w_state_nxt = WAIT_LOAD;
            WAIT_LOAD: begin
                if (comp_load_i) begin
                    w_state_nxt     = IDLE;
                    w_comp_init_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT_LOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_samp_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == ACCUM);
    end

    // Control registers: state, ready, start pulse, system tag, current mode.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_samp_ready <= 1'b1;
            r_comp_init  <= 1'b0;
            r_index      <= 8'd0;
            r_mode_cur   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_samp_ready <= w_samp_ready_nxt;
            r_comp_init  <= w_comp_init_nxt;
            if (r_comp_init) begin
                r_index <= r_index + 8'd1;
            end
            if (w_first) begin
                r_mode_cur <= affine_param6_i;
            end
        end
    end

    // Stage 2: the first sample loads, later samples add with modular wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_affine6 <= 1'b0;
        end else if (w_p_valid) begin
            for (int k = 0; k < AME_NUM_TRI; k++) begin
                r_acc_a[k] <= w_p_first ? sext(w_prod_a[k]) : r_acc_a[k] + sext(w_prod_a[k]);
            end
            for (int k = 0; k < AME_NUM_PARAM; k++) begin
                r_acc_b[k] <= w_p_first ? sext(w_prod_b[k]) : r_acc_b[k] + sext(w_prod_b[k]);
            end
            if (w_p_first) begin
                r_affine6 <= w_p_mode;
            end
        end
    end

    // Expand the stored triangle into the full symmetric matrix plus the B column.
    always_comb begin
        comp_data_o = '0;
        for (int r = 0; r < AME_NUM_PARAM; r++) begin
            for (int c = 0; c < AME_NUM_PARAM; c++) begin
                comp_data_o[r][c] = r_acc_a[tri_idx(r, c)];
            end
            comp_data_o[r][AME_NUM_COL-1] = r_acc_b[r];
        end
    end

    assign samp_ready_o      = r_samp_ready;
    assign comp_init_o       = r_comp_init;
    assign comp_data_index_o = r_index;
    assign affine_param6_o   = r_affine6;

endmodule

// File: tb/tb_ame_equation_builder.sv
// Scoreboard bench for ame_equation_builder: directed systems push expected matrices,
// a monitor pops and compares them on every comp_init pulse.
`timescale 1ns/1ps
module tb_ame_equation_builder;

    localparam int CDB = 64;
    localparam int SB  = 24;

    logic                      clk_i = 1'b0;
    logic                      rst_n_i = 1'b0;
    logic                      samp_valid_i = 1'b0;
    logic                      samp_ready_o;
    logic                      samp_last_i = 1'b0;
    logic [5:0][SB-1:0]        samp_coef_i = '0;
    logic [SB-1:0]             samp_resid_i = '0;
    logic                      affine_param6_i = 1'b0;
    logic                      comp_load_i = 1'b0;
    logic                      comp_init_o;
    logic [5:0][6:0][CDB-1:0]  comp_data_o;
    logic [7:0]                comp_data_index_o;
    logic                      affine_param6_o;

    ame_equation_builder #(.COMP_DATA_BITS(CDB), .SAMP_BITS(SB)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .samp_valid_i      (samp_valid_i),
        .samp_ready_o      (samp_ready_o),
        .samp_last_i       (samp_last_i),
        .samp_coef_i       (samp_coef_i),
        .samp_resid_i      (samp_resid_i),
        .affine_param6_i   (affine_param6_i),
        .comp_load_i       (comp_load_i),
        .comp_init_o       (comp_init_o),
        .comp_data_o       (comp_data_o),
        .comp_data_index_o (comp_data_index_o),
        .affine_param6_o   (affine_param6_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]               tag;
        logic                     mode;
        logic [5:0][6:0][CDB-1:0] m;
    } exp_t;

    exp_t                     exp_q[$];
    int                       checks = 0;
    int                       errors = 0;
    int                       pulses = 0;
    logic [5:0][6:0][CDB-1:0] mdl = '0;
    logic                     mdl_mode = 1'b0;
    logic                     sys_open = 1'b0;
    logic [7:0]               exp_tag = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [5:0][SB-1:0] mkc(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5);
        logic [5:0][SB-1:0] v;
        v[0] = a0[SB-1:0];
        v[1] = a1[SB-1:0];
        v[2] = a2[SB-1:0];
        v[3] = a3[SB-1:0];
        v[4] = a4[SB-1:0];
        v[5] = a5[SB-1:0];
        return v;
    endfunction

    // Reference: straightforward sum of c*c^T and c*r over the accepted samples.
    task automatic model_add(input logic [5:0][SB-1:0] c, input logic [SB-1:0] r, input logic mode);
        longint cv[6];
        longint rv;
        if (!sys_open) begin
            mdl      = '0;
            mdl_mode = mode;
            sys_open = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            cv[k] = (!mdl_mode && k < 2) ? 64'sd0 : longint'($signed(c[k]));
        end
        rv = longint'($signed(r));
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                mdl[i][j] = mdl[i][j] + cv[i] * cv[j];
            end
            mdl[i][6] = mdl[i][6] + cv[i] * rv;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [5:0][SB-1:0] c, input int r, input logic last, input logic mode);
        int n = 0;
        exp_t e;
        samp_coef_i     = c;
        samp_resid_i    = r[SB-1:0];
        samp_last_i     = last;
        affine_param6_i = mode;
        samp_valid_i    = 1'b1;
        while (!samp_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("accept_ready", 64'(samp_ready_o), 64'd1);
        if (samp_ready_o) begin
            @(posedge clk_i);
            model_add(c, r[SB-1:0], mode);
            if (last) begin
                e.tag  = exp_tag;
                e.mode = mdl_mode;
                e.m    = mdl;
                exp_q.push_back(e);
                exp_tag  = exp_tag + 8'd1;
                sys_open = 1'b0;
            end
            @(negedge clk_i);
        end
        samp_valid_i = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        while (!comp_init_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(samp_ready_o), 64'd1);
        chk({tag, "_init"}, 64'(comp_init_o), 64'd0);
        chk({tag, "_index"}, 64'(comp_data_index_o), 64'd0);
        chk({tag, "_mode"}, 64'(affine_param6_o), 64'd0);
        chk({tag, "_data_nonzero"}, 64'(comp_data_o != '0), 64'd0);
    endtask

    // Monitor: every start pulse must match the oldest pending system.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_n_i && comp_init_o) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got comp_init=1 with no system pending, required 0");
            end else begin
                e = exp_q.pop_front();
                chk("tag", 64'(comp_data_index_o), 64'(e.tag));
                chk("mode", 64'(affine_param6_o), 64'(e.mode));
                for (int r = 0; r < 6; r++) begin
                    for (int c = 0; c < 7; c++) begin
                        chk($sformatf("data[%0d][%0d]", r, c), comp_data_o[r][c], e.m[r][c]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_n_i     = 1'b1;
        comp_load_i = 1'b1;
        @(negedge clk_i);

        // 6-param single sample: earliest pulse and hand values.
        send(mkc(1, 2, 3, 4, 5, 6), 7, 1'b1, 1'b1);
        wait_pulse(n);
        chk("latency", 64'(n), 64'd3);
        chk("A55", comp_data_o[5][5], 64'd36);
        chk("A05", comp_data_o[0][5], 64'd6);
        chk("A50", comp_data_o[5][0], 64'd6);
        chk("A23", comp_data_o[2][3], 64'd12);
        chk("B2", comp_data_o[2][6], 64'd21);
        chk("tag0", 64'(comp_data_index_o), 64'd0);

        // 4-param: rows/cols 0,1 vanish.
        send(mkc(1, 2, 3, 4, 5, 6), 7, 1'b1, 1'b0);
        wait_pulse(n);
        chk("A25_4p", comp_data_o[2][5], 64'd18);
        chk("A33_4p", comp_data_o[3][3], 64'd16);
        chk("B5_4p", comp_data_o[5][6], 64'd42);
        chk("A01_4p", comp_data_o[0][1], 64'd0);
        chk("B1_4p", comp_data_o[1][6], 64'd0);
        chk("mode_4p", 64'(affine_param6_o), 64'd0);

        // Two-sample accumulation with negative values.
        send(mkc(-3, 0, 0, 0, 0, 0), 5, 1'b0, 1'b1);
        send(mkc(2, 0, 0, 0, 0, 0), -1, 1'b1, 1'b1);
        wait_pulse(n);
        chk("A00_acc", comp_data_o[0][0], 64'd13);
        chk("B0_acc", comp_data_o[0][6], 64'hFFFF_FFFF_FFFF_FFEF);

        // Solver busy: no ready, no pulse, ignored samples while waiting.
        comp_load_i = 1'b0;
        send(mkc(1, -2, 3, -4, 5, -6), 11, 1'b1, 1'b1);
        samp_coef_i  = mkc(100, 200, 300, 400, 500, 600);
        samp_resid_i = 24'd999;
        samp_last_i  = 1'b1;
        samp_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("busy_ready", 64'(samp_ready_o), 64'd0);
            chk("busy_init", 64'(comp_init_o), 64'd0);
            @(negedge clk_i);
        end
        samp_valid_i = 1'b0;
        comp_load_i  = 1'b1;
        wait_pulse(n);
        chk("load_latency", 64'(n), 64'd1);

        // 257 back-to-back single-sample systems; tag wraps through 255 -> 0.
        for (int i = 0; i < 257; i++) begin
            send(mkc(i, -i, i + 1, 2, -1, i % 7), i - 100, 1'b1, 1'(i % 2));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_257", 64'(exp_q.size()), 64'd0);

        // Reset while accumulating discards everything.
        send(mkc(5, 6, 7, 8, 9, 10), 3, 1'b0, 1'b1);
        send(mkc(1, 1, 1, 1, 1, 1), 2, 1'b0, 1'b1);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sys_open = 1'b0;
        exp_tag  = 8'd0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        send(mkc(0, 0, 2, 0, 0, 3), -4, 1'b1, 1'b0);
        wait_pulse(n);
        chk("post_reset_A25", comp_data_o[2][5], 64'd6);
        chk("post_reset_B5", comp_data_o[5][6], 64'hFFFF_FFFF_FFFF_FFF4);
        chk("post_reset_tag", 64'(comp_data_index_o), 64'd0);

        repeat (8) @(negedge clk_i);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        k = 1 + 1 + 1 + 1 + 257 + 1;
        chk("pulse_count", 64'(pulses), 64'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
